// File: rtl/adder_tree_ich_pipe.sv
// Flow-controlled N_CH-input adder tree. Latency ceil(clog2(N_CH)/PIPE_EVERY); stages collapse bubbles, stall only when full.
// ADDER_TREE_ICH_SAT_EN: saturate out_sum on overflow instead of wrapping.
module adder_tree_ich_pipe #(
  parameter int N_CH       = 32,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*IN_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_sum,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_ovf
);
  localparam int LEVELS = $clog2(N_CH);
  localparam int NP     = 1 << LEVELS;
  localparam int FULL_W = IN_WIDTH + LEVELS;
  localparam int NS     = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;

  logic [NP*FULL_W-1:0] ext_in;
  logic [FULL_W-1:0]    full_sum;

  // Channels beyond N_CH are zero padding up to the next power of two.
  for (genvar c = 0; c < NP; c++) begin : g_ext
    if (c < N_CH) begin : g_ch
      logic [IN_WIDTH-1:0] x;
      assign x = in_data[c*IN_WIDTH +: IN_WIDTH];
      assign ext_in[c*FULL_W +: FULL_W] = {{LEVELS{(SIGNED != 0) & x[IN_WIDTH-1]}}, x};
    end else begin : g_pad
      assign ext_in[c*FULL_W +: FULL_W] = '0;
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_stg
    localparam int LO   = s * PIPE_EVERY;
    localparam int HI   = (LO + PIPE_EVERY < LEVELS) ? LO + PIPE_EVERY : LEVELS;
    localparam int CIN  = NP >> LO;
    localparam int COUT = NP >> HI;

    logic [CIN*FULL_W-1:0]  src;
    logic                   up_v;
    logic [TAG_WIDTH-1:0]   up_t;
    logic                   nxt_rdy;
    logic                   rdy;
    logic                   v_q, v_d;
    logic [TAG_WIDTH-1:0]   t_q;
    logic [COUT*FULL_W-1:0] d_q, d_d;

    if (s == 0) begin : g_from_in
      assign src  = ext_in;
      assign up_v = in_valid;
      assign up_t = in_tag;
    end else begin : g_from_stg
      assign src  = g_stg[s-1].d_q;
      assign up_v = g_stg[s-1].v_q;
      assign up_t = g_stg[s-1].t_q;
    end

    if (s == NS - 1) begin : g_rdy_out
      assign nxt_rdy = out_ready;
    end else begin : g_rdy_stg
      assign nxt_rdy = g_stg[s+1].rdy;
    end
    assign rdy = ~v_q | nxt_rdy;

    for (genvar k = 0; k <= HI - LO; k++) begin : g_lvl
      logic [(CIN>>k)*FULL_W-1:0] v;
      if (k == 0) begin : g_base
        assign v = src;
      end else begin : g_add
        for (genvar i = 0; i < (CIN >> k); i++) begin : g_pair
          assign v[i*FULL_W +: FULL_W] = g_lvl[k-1].v[2*i*FULL_W +: FULL_W]
                                       + g_lvl[k-1].v[(2*i+1)*FULL_W +: FULL_W];
        end
      end
    end
    assign d_d = g_lvl[HI-LO].v;

    always_comb begin
      v_d = v_q;
      if (flush)    v_d = 1'b0;
      else if (rdy) v_d = up_v;
    end

    // Data and tag only move with the ready chain, so a stalled output holds still.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        t_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        if (rdy) begin
          t_q <= up_t;
          d_q <= d_d;
        end
      end
    end
  end

  assign in_ready  = g_stg[0].rdy;
  assign out_valid = g_stg[NS-1].v_q;
  assign out_tag   = g_stg[NS-1].t_q;
  assign full_sum  = g_stg[NS-1].d_q;

  if (OUT_WIDTH >= FULL_W) begin : g_wide
    assign out_ovf = 1'b0;
    if (OUT_WIDTH == FULL_W) begin : g_same
      assign out_sum = full_sum;
    end else begin : g_extend
      assign out_sum = {{(OUT_WIDTH-FULL_W){(SIGNED != 0) & full_sum[FULL_W-1]}}, full_sum};
    end
  end else begin : g_narrow
    logic ovf;
    if (SIGNED != 0) begin : g_sovf
      assign ovf = full_sum[FULL_W-1:OUT_WIDTH-1] != {(FULL_W-OUT_WIDTH+1){full_sum[FULL_W-1]}};
    end else begin : g_uovf
      assign ovf = |full_sum[FULL_W-1:OUT_WIDTH];
    end
    assign out_ovf = ovf;
`ifdef ADDER_TREE_ICH_SAT_EN
    logic [OUT_WIDTH-1:0] sat;
    if (SIGNED != 0) begin : g_ssat
      assign sat = full_sum[FULL_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin : g_usat
      assign sat = '1;
    end
    assign out_sum = ovf ? sat : full_sum[OUT_WIDTH-1:0];
`else
    assign out_sum = full_sum[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_adder_tree_ich_pipe.sv
// Scoreboard bench for adder_tree_ich_pipe: three parameterisations, expected results queued at acceptance.
module tb_adder_tree_ich_pipe;
  typedef struct {
    logic [31:0] sum;
    logic [7:0]  tag;
    logic        ovf;
    int          ocyc;
  } exp_t;

`ifdef ADDER_TREE_ICH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: default parameters
  logic         fl0 = 0, iv0 = 0, or0 = 1;
  logic [511:0] id0 = '0;
  logic [7:0]   it0 = '0;
  logic         ir0, ov0, of0;
  logic [31:0]  os0;
  logic [7:0]   ot0;
  // DUT1: N_CH=5, PIPE_EVERY=1
  logic         fl1 = 0, iv1 = 0, or1 = 1;
  logic [79:0]  id1 = '0;
  logic [7:0]   it1 = '0;
  logic         ir1, ov1, of1;
  logic [31:0]  os1;
  logic [7:0]   ot1;
  // DUT2: OUT_WIDTH=18
  logic         fl2 = 0, iv2 = 0, or2 = 1;
  logic [511:0] id2 = '0;
  logic [7:0]   it2 = '0;
  logic         ir2, ov2, of2;
  logic [17:0]  os2;
  logic [7:0]   ot2;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  adder_tree_ich_pipe u_dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .in_tag(it0), .out_valid(ov0), .out_ready(or0), .out_sum(os0), .out_tag(ot0), .out_ovf(of0));

  adder_tree_ich_pipe #(.N_CH(5), .PIPE_EVERY(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_tag(it1), .out_valid(ov1), .out_ready(or1), .out_sum(os1), .out_tag(ot1), .out_ovf(of1));

  adder_tree_ich_pipe #(.OUT_WIDTH(18)) u_dut2 (
    .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .in_tag(it2), .out_valid(ov2), .out_ready(or2), .out_sum(os2), .out_tag(ot2), .out_ovf(of2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] ramp(input int base, input int step);
    logic [511:0] r;
    r = '0;
    for (int c = 0; c < 32; c++) begin
      int v;
      v = base + step * c;
      r[c*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected_output actual_tag=0x%02h required=none", ot0);
      end else begin
        e0 = q0.pop_front();
        chk("d0_sum", os0, e0.sum);
        chk("d0_tag", {24'b0, ot0}, {24'b0, e0.tag});
        chk("d0_ovf", {31'b0, of0}, {31'b0, e0.ovf});
        if (e0.ocyc >= 0) chk("d0_latency", cyc, e0.ocyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_output actual_tag=0x%02h required=none", ot1);
      end else begin
        e1 = q1.pop_front();
        chk("d1_sum", os1, e1.sum);
        chk("d1_tag", {24'b0, ot1}, {24'b0, e1.tag});
        chk("d1_ovf", {31'b0, of1}, {31'b0, e1.ovf});
        chk("d1_latency", cyc, e1.ocyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected_output actual_tag=0x%02h required=none", ot2);
      end else begin
        e2 = q2.pop_front();
        chk("d2_sum", {14'b0, os2}, e2.sum);
        chk("d2_tag", {24'b0, ot2}, {24'b0, e2.tag});
        chk("d2_ovf", {31'b0, of2}, {31'b0, e2.ovf});
        chk("d2_latency", cyc, e2.ocyc);
      end
    end
  end

  // Drivers are called at posedge+1 and return at posedge+1 after acceptance.
  task automatic send0(input logic [511:0] d, input logic [7:0] t, input int s,
                       input bit push, input bit lat);
    int n;
    n = 0;
    iv0 = 1'b1; id0 = d; it0 = t;
    @(negedge clk);
    while (!ir0 && n < 100) begin @(negedge clk); n++; end
    if (!ir0) begin
      checks++; errors++;
      $display("FAIL d0_accept_timeout actual=in_ready_low required=accept tag=0x%02h", t);
    end else if (push) begin
      q0.push_back('{sum: 32'(s), tag: t, ovf: 1'b0, ocyc: lat ? cyc + 3 : -1});
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
  endtask

  task automatic send1(input logic [79:0] d, input logic [7:0] t, input int s);
    iv1 = 1'b1; id1 = d; it1 = t;
    @(negedge clk);
    chk("d1_in_ready", {31'b0, ir1}, 32'd1);
    q1.push_back('{sum: 32'(s), tag: t, ovf: 1'b0, ocyc: cyc + 3});
    @(posedge clk); #1;
    iv1 = 1'b0;
  endtask

  task automatic send2(input logic [511:0] d, input logic [7:0] t, input logic [31:0] s,
                       input logic ovf);
    iv2 = 1'b1; id2 = d; it2 = t;
    @(negedge clk);
    chk("d2_in_ready", {31'b0, ir2}, 32'd1);
    q2.push_back('{sum: s, tag: t, ovf: ovf, ocyc: cyc + 3});
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk(nm, q0.size() + q1.size() + q2.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, ov0}, 32'd0);
    chk("rst_out_sum", os0, 32'd0);
    chk("rst_out_tag", {24'b0, ot0}, 32'd0);
    chk("rst_out_ovf", {31'b0, of0}, 32'd0);
    chk("rst_in_ready", {31'b0, ir0}, 32'd1);
    chk("rst_d1_out_valid", {31'b0, ov1}, 32'd0);
    @(posedge clk); #1;

    // Basic sums and signed operands
    send0(ramp(1, 0), 8'hA5, 32, 1, 1);
    drain("drain_t1");
    d = '0;
    for (int c = 0; c < 32; c++) d[c*16 +: 16] = (c % 2 == 0) ? 16'h7FFF : 16'h8000;
    send0(d, 8'h11, -16, 1, 1);
    send0(ramp(-16, 1), 8'h12, -16, 1, 1);
    send0(ramp(-32768, 0), 8'h13, -1048576, 1, 1);
    drain("drain_t2");

    // Back-to-back stream: consecutive outputs, tags in order
    for (int i = 0; i < 10; i++) send0(ramp(i, 1), 8'(i), 32 * i + 496, 1, 1);
    drain("drain_t3a");

    // Downstream stall: fills all three stages then backpressures
    or0 = 1'b0;
    send0(ramp(100, 0), 8'd20, 3200, 1, 0);
    send0(ramp(200, 0), 8'd21, 6400, 1, 0);
    send0(ramp(300, 0), 8'd22, 9600, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, ir0}, 32'd0);
      chk("stall_out_valid", {31'b0, ov0}, 32'd1);
      chk("stall_out_sum", os0, 32'd3200);
      chk("stall_out_tag", {24'b0, ot0}, 32'd20);
    end
    @(posedge clk); #1;
    or0 = 1'b1;
    drain("drain_t3b");

    // Padded 5-channel tree, one register per level
    send1({16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 8'h41, 15);
    send1({16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 8'h42, -15);
    drain("drain_t4");

    // Narrow 18-bit output: overflow and wrap/saturate boundaries
    send2(ramp(32767, 0), 8'h51, SAT ? 32'h1FFFF : 32'h3FFE0, 1'b1);
    send2(ramp(-1, 0), 8'h52, 32'h3FFE0, 1'b0);
    send2(ramp(-32768, 0), 8'h53, SAT ? 32'h20000 : 32'h00000, 1'b1);
    d = '0;
    for (int c = 0; c < 4; c++) d[c*16 +: 16] = 16'h7FFF;
    d[4*16 +: 16] = 16'd3;
    send2(d, 8'h54, 32'h1FFFF, 1'b0);
    d[4*16 +: 16] = 16'd4;
    send2(d, 8'h55, SAT ? 32'h1FFFF : 32'h20000, 1'b1);
    drain("drain_t5");

    // Flush with stalled output: everything in flight is dropped
    or0 = 1'b0;
    send0(ramp(1, 0), 8'h61, 0, 0, 0);
    send0(ramp(2, 0), 8'h62, 0, 0, 0);
    send0(ramp(3, 0), 8'h63, 0, 0, 0);
    fl0 = 1'b1;
    @(posedge clk); #1;
    fl0 = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, ov0}, 32'd0);
    chk("flush_in_ready", {31'b0, ir0}, 32'd1);
    @(posedge clk); #1;
    or0 = 1'b1;
    send0(ramp(7, 0), 8'h66, 224, 1, 1);
    drain("drain_t6a");

    // Flush coinciding with an output handshake: that beat still goes out
    or0 = 1'b0;
    send0(ramp(9, 0), 8'h71, 288, 1, 0);
    send0(ramp(10, 0), 8'h72, 0, 0, 0);
    send0(ramp(11, 0), 8'h73, 0, 0, 0);
    or0 = 1'b1; fl0 = 1'b1; iv0 = 1'b1; id0 = ramp(12, 0); it0 = 8'h74;
    @(posedge clk); #1;
    fl0 = 1'b0; iv0 = 1'b0;
    @(negedge clk);
    chk("flush_hs_out_valid", {31'b0, ov0}, 32'd0);
    chk("flush_hs_in_ready", {31'b0, ir0}, 32'd1);
    repeat (5) @(negedge clk);
    drain("drain_t6b");

    // Asynchronous reset mid-stream
    or0 = 1'b0;
    send0(ramp(13, 0), 8'h81, 0, 0, 0);
    send0(ramp(14, 0), 8'h82, 0, 0, 0);
    send0(ramp(15, 0), 8'h83, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, ov0}, 32'd0);
    chk("arst_out_sum", os0, 32'd0);
    chk("arst_out_tag", {24'b0, ot0}, 32'd0);
    chk("arst_out_ovf", {31'b0, of0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    or0 = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {31'b0, ir0}, 32'd1);
    repeat (6) @(negedge clk);
    chk("arst_no_output", {31'b0, ov0}, 32'd0);
    drain("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_tree_ich_pipe.md
Name: adder_tree_ich_pipe

Overview:
Parametrised, flow-controlled successor to the fixed 32-channel input-channel adder tree. Reduces N_CH partial sums of IN_WIDTH bits to one sum. Register placement is configurable, and the block uses valid/ready handshakes with per-stage bubble collapsing, a sideband tag and a synchronous flush. Sits between the PE array psum outputs and the ich accumulator / output buffer.

Parameters:
N_CH, 32, number of input channels; any value >=2; non-power-of-2 counts are zero-padded to the next power of 2.
IN_WIDTH, 16, width of each channel psum.
OUT_WIDTH, 32, output width; rules under "Arithmetic".
SIGNED, 1, 1 = two's-complement operands with sign extension; 0 = unsigned with zero extension.
PIPE_EVERY, 2, insert a register after every PIPE_EVERY adder levels.
TAG_WIDTH, 8, width of the sideband tag carried alongside the data.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous; clears all pipeline valids
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  N_CH*IN_WIDTH  channel c occupies [c*IN_WIDTH +: IN_WIDTH]
in_tag  in  TAG_WIDTH  sideband travelling with the beat
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_sum  out  OUT_WIDTH  reduced sum
out_tag  out  TAG_WIDTH  tag of the beat that produced out_sum
out_ovf  out  1  result exceeded the OUT_WIDTH range (see Arithmetic)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset clears all stage valids, data and tag registers to 0. Therefore out_valid=0, out_sum=0, out_tag=0 and out_ovf=0. in_ready=1 after reset.
- Structure:
  - LEVELS = clog2(N_CH). Level k adds adjacent pairs of level k-1.
  - A register stage follows level k when k % PIPE_EVERY == 0. A register stage always follows the final level.
  - Latency L = ceil(LEVELS/PIPE_EVERY) cycles from input acceptance to out_valid. For N_CH=32, PIPE_EVERY=2, L=3.
- Arithmetic:
  - Internal full precision FULL_W = IN_WIDTH + LEVELS; no overflow occurs internally.
  - Output is the low OUT_WIDTH bits when OUT_WIDTH < FULL_W, and sign/zero-extended otherwise.
  - out_ovf=1 when the full-precision value is not representable in OUT_WIDTH (signed or unsigned per SIGNED). out_ovf is always 0 when OUT_WIDTH >= FULL_W.
- Handshake:
  - Each register stage s holds v_s, data and tag.
  - ready_L = out_ready; ready_s = ~v_s | ready_{s+1}; in_ready = ready_1.
  - Stage s loads from stage s-1 (or from the input) when ready_s. Its new v_s is the upstream valid.
  - A transfer happens when valid & ready at either boundary.
  - Bubbles collapse: a stalled downstream does not block upstream stages that are empty.
  - Full throughput: 1 beat/cycle while out_ready=1.
  - out_sum, out_tag and out_ovf hold stable while out_valid=1 and out_ready=0.
- Flush: clears all v_s the next cycle; data is not cleared. The input beat presented in the flush cycle is dropped. in_ready=1 the cycle after flush.
- Simultaneous flush and output handshake: the output transfer in the flush cycle still completes (downstream sees it). All other beats are discarded.
- Reset mid-operation: all in-flight beats are lost; no partial output is produced.
- Ordering: beats exit in acceptance order, and tag pairing is preserved.

Optional Feature:
Macro ADDER_TREE_ICH_SAT_EN.
- Defined: when out_ovf=1, out_sum saturates. Signed mode gives 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1) by sign. Unsigned mode gives 2^OUT_WIDTH-1. out_ovf is still reported.
- Undefined: out_sum wraps (low bits); out_ovf is still reported. No saturation logic is synthesised.

Test Plan:
1. Default params, all 32 channels = 1, out_ready=1 -> out_valid 3 cycles after acceptance, out_sum=32, tag echoed.
2. SIGNED=1, channels alternate +32767/-32768 -> out_sum=-16. Channels 0..31 = c-16 -> out_sum=-16.
3. Stream 10 back-to-back beats with tags 0..9 and out_ready=1 -> 10 consecutive out_valid cycles, tags in order 0..9. Then hold out_ready=0 for 5 cycles -> in_ready drops once all 3 stages are full, and out_sum stays stable.
4. N_CH=5 (padded to 8), PIPE_EVERY=1, inputs 1..5 -> L=3, out_sum=15.
5. OUT_WIDTH=18, SIGNED=1, all channels = 32767 (full sum 1048544) -> out_ovf=1. Without the macro out_sum=wrapped low 18 bits (0x3FFE0 read as -32). With the macro out_sum=131071.
6. Fill pipeline with 3 beats, assert flush with out_ready=0 -> next cycle out_valid=0 and in_ready=1. A new beat emerges after L cycles with the correct sum. Assert rst mid-stream -> outputs return to 0 immediately.
